// File: rtl/gray_codec_pkg.sv
// Shared mode constants and width-parametrised Gray conversion helpers for gray_codec.
package gray_codec_pkg;

   localparam logic MODE_B2G = 1'b0;
   localparam logic MODE_G2B = 1'b1;

   localparam int unsigned MAX_W = 32;

   function automatic logic [MAX_W-1:0] width_mask(input int unsigned width);
      logic [MAX_W-1:0] m;
      m = '0;
      for (int unsigned k = 0; k < MAX_W; k++) begin
         if (k < width) m[k] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b,
                                                 input int unsigned     width);
      logic [MAX_W-1:0] m;
      m = b & width_mask(width);
      return m ^ (m >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it within the word.
   function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g,
                                                 input int unsigned     width);
      logic [MAX_W-1:0] m;
      logic [MAX_W-1:0] b;
      m = g & width_mask(width);
      b = '0;
      for (int unsigned k = 0; k < MAX_W; k++) begin
         b[k] = ^(m >> k);
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_pipe_stage.sv
// Single valid/ready register slice; loads when empty or when its contents leave.
module gray_pipe_stage #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             valid;
   logic [WIDTH-1:0] data;

   assign in_ready  = !valid || out_ready;
   assign out_valid = valid;
   assign out_data  = data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (in_ready) begin
         valid <= in_valid;
         if (in_valid) data <= in_data;
      end
   end

endmodule

// File: rtl/gray_codec.sv
// Two-stage binary<->Gray converter with valid/ready handshaking.
// Optional Gray adjacency checker enabled by defining GRAY_CODEC_ADJ_CHECK_EN.
module gray_codec
   import gray_codec_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_mode,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             adj_err
);

`ifdef GRAY_CODEC_ADJ_CHECK_EN
   localparam int unsigned S2_W = WIDTH + 1;
`else
   localparam int unsigned S2_W = WIDTH;
`endif

   logic             s1_in_ready;
   logic             s1_valid;
   logic             s2_in_ready;
   logic [WIDTH:0]   s1_out;
   logic             s1_mode;
   logic [WIDTH-1:0] s1_word;
   logic [WIDTH-1:0] result;
   logic [S2_W-1:0]  s2_in;
   logic [S2_W-1:0]  s2_out;

   assign in_ready = rst_n && s1_in_ready;

   gray_pipe_stage #(.WIDTH(WIDTH + 1)) u_stage1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (s1_in_ready),
      .in_data   ({in_mode, in_data}),
      .out_valid (s1_valid),
      .out_ready (s2_in_ready),
      .out_data  (s1_out)
   );

   assign {s1_mode, s1_word} = s1_out;

   always_comb begin
      result = '0;
      if (s1_mode == MODE_G2B) result = WIDTH'(gray2bin(MAX_W'(s1_word), WIDTH));
      else                     result = WIDTH'(bin2gray(MAX_W'(s1_word), WIDTH));
   end

`ifdef GRAY_CODEC_ADJ_CHECK_EN
   logic             hist_valid;
   logic [WIDTH-1:0] hist;
   logic [WIDTH-1:0] diff;
   logic             adj_flag;
   logic             s1_xfer;

   // History is tracked at the stage-1 exit; order is identical to acceptance order.
   assign s1_xfer  = s1_valid && s2_in_ready;
   assign diff     = s1_word ^ hist;
   assign adj_flag = (s1_mode == MODE_G2B) && hist_valid &&
                     (|(diff & (diff - WIDTH'(1))));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_valid <= 1'b0;
         hist       <= '0;
      end else if (s1_xfer && (s1_mode == MODE_G2B)) begin
         hist_valid <= 1'b1;
         hist       <= s1_word;
      end
   end

   assign s2_in    = {adj_flag, result};
   assign out_data = s2_out[WIDTH-1:0];
   assign adj_err  = s2_out[WIDTH];
`else
   assign s2_in    = result;
   assign out_data = s2_out;
   assign adj_err  = 1'b0;
`endif

   gray_pipe_stage #(.WIDTH(S2_W)) u_stage2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s1_valid),
      .in_ready  (s2_in_ready),
      .in_data   (s2_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (s2_out)
   );

endmodule
